// File: rtl/mult_rc_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier with mod-3 residue check.
package mult_rc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter must reach WIDTH, so it needs clog2(WIDTH+1) bits.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

  // Fold one 2-bit digit into a running residue; 4 == 1 (mod 3) makes digit order irrelevant.
  function automatic logic [1:0] mod3_fold(input logic [1:0] r, input logic [1:0] pair);
    logic [2:0] t;
    t = 3'(r) + 3'(pair);
    if (t >= 3'd3) t = t - 3'd3;
    return t[1:0];
  endfunction

  function automatic logic [1:0] mod3(input logic [63:0] x);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 32; i++) r = mod3_fold(r, x[2*i +: 2]);
    return r;
  endfunction

endpackage

// File: rtl/mod3_residue.sv
// Combinational x mod 3 by summing 2-bit digits with a running residue.
module mod3_residue
  import mult_rc_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] i_x,
  output logic [1:0]   o_res
);

  localparam int unsigned NP = (W + 1) / 2;
  localparam int unsigned XW = 2 * NP;

  logic [XW-1:0] w_x;

  assign w_x = XW'(i_x);

  always_comb begin
    o_res = 2'd0;
    for (int i = 0; i < NP; i++) o_res = mod3_fold(o_res, w_x[2*i +: 2]);
  end

endmodule

// File: rtl/mult_seq_unsigned_rc.sv
// Radix-2 shift-add unsigned multiplier behind valid/ready, with concurrent mod-3 residue check.
module mult_seq_unsigned_rc
  import mult_rc_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned EARLY_TERM = 0,
  parameter int unsigned RC_EN      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p,
  output logic               fault
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned AW = WIDTH + 1;
  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;

  logic [AW-1:0]    w_sum;
  logic [PW-1:0]    w_step_acc;
  logic [PW-1:0]    w_term_acc;
  logic [CW-1:0]    w_shamt;
  logic [WIDTH-1:0] w_mplier_sh;
  logic             w_last;
  logic             w_early;
  logic             w_accept;

  // Upper half plus multiplicand; the carry lands in the top bit and is shifted down.
  assign w_sum       = AW'(r_acc[PW-1:WIDTH]) + AW'(r_mcand & {WIDTH{r_mplier[0]}});
  assign w_step_acc  = {w_sum, r_acc[WIDTH-1:1]};
  assign w_mplier_sh = r_mplier >> 1;
  assign w_last      = (r_cnt == CW'(WIDTH - 1));
  assign w_early     = (EARLY_TERM != 0) && (w_mplier_sh == '0);
  assign w_shamt     = CW'(WIDTH - 1) - r_cnt;
  assign w_term_acc  = w_step_acc >> w_shamt;

  assign in_ready  = (r_state == IDLE) || ((r_state == DONE) && out_ready);
  assign out_valid = (r_state == DONE);
  assign p         = r_acc;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        BUSY: begin
          r_acc    <= w_early ? w_term_acc : w_step_acc;
          r_mplier <= w_mplier_sh;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last || w_early) r_state <= DONE;
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        IDLE: ;
        default: r_state <= IDLE;
      endcase
      // Capture overrides the retire-to-IDLE path for back-to-back operation.
      if (w_accept) begin
        r_mcand  <= a;
        r_mplier <= b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_state  <= BUSY;
      end
    end
  end

  if (RC_EN != 0) begin : g_rc
    logic [1:0] w_res_a;
    logic [1:0] w_res_b;
    logic [1:0] w_res_p;
    logic [3:0] w_rr;
    logic [1:0] r_ra;
    logic [1:0] r_rb;

    mod3_residue #(.W(WIDTH)) u_res_a (.i_x(a),     .o_res(w_res_a));
    mod3_residue #(.W(WIDTH)) u_res_b (.i_x(b),     .o_res(w_res_b));
    mod3_residue #(.W(PW))    u_res_p (.i_x(r_acc), .o_res(w_res_p));

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_ra <= 2'd0;
        r_rb <= 2'd0;
      end else if (w_accept) begin
        r_ra <= w_res_a;
        r_rb <= w_res_b;
      end
    end

    assign w_rr  = 4'(r_ra) * 4'(r_rb);
    assign fault = out_valid && (w_res_p != mod3(64'(w_rr)));
  end else begin : g_no_rc
    assign fault = 1'b0;
  end

endmodule

// File: tb/tb_mult_seq_unsigned_rc.sv
// Directed bench for mult_seq_unsigned_rc across several parameterisations.
module tb_mult_seq_unsigned_rc;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=4 pair (RC on / RC off) sharing stimulus
  logic       v4 = 1'b0, r4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ir4, ov4, f4, ir4n, ov4n, f4n;
  logic [7:0] p4, p4n;

  // WIDTH=8 early-termination
  logic        v8 = 1'b0, r8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        ir8, ov8, f8;
  logic [15:0] p8;

  // WIDTH=16 and WIDTH=32 sharing stimulus
  logic        vw = 1'b0, rw = 1'b0;
  logic [31:0] aw = '0, bw = '0;
  logic        ir16, ov16, f16, ir32, ov32, f32;
  logic [31:0] p16;
  logic [63:0] p32;

  int n_checks = 0;
  int n_fail   = 0;
  int lat;

  mult_seq_unsigned_rc #(.WIDTH(4), .EARLY_TERM(0), .RC_EN(1)) dut4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(r4), .p(p4), .fault(f4));

  mult_seq_unsigned_rc #(.WIDTH(4), .EARLY_TERM(0), .RC_EN(0)) dut4n (
    .clk(clk), .rst(rst), .in_valid(v4), .in_ready(ir4n), .a(a4), .b(b4),
    .out_valid(ov4n), .out_ready(r4), .p(p4n), .fault(f4n));

  mult_seq_unsigned_rc #(.WIDTH(8), .EARLY_TERM(1), .RC_EN(1)) dut8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(r8), .p(p8), .fault(f8));

  mult_seq_unsigned_rc #(.WIDTH(16), .EARLY_TERM(0), .RC_EN(1)) dut16 (
    .clk(clk), .rst(rst), .in_valid(vw), .in_ready(ir16), .a(aw[15:0]), .b(bw[15:0]),
    .out_valid(ov16), .out_ready(rw), .p(p16), .fault(f16));

  mult_seq_unsigned_rc #(.WIDTH(32), .EARLY_TERM(0), .RC_EN(1)) dut32 (
    .clk(clk), .rst(rst), .in_valid(vw), .in_ready(ir32), .a(aw), .b(bw),
    .out_valid(ov32), .out_ready(rw), .p(p32), .fault(f32));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Latency = edges from the accept edge up to the first edge that sees out_valid.
  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, output int tl);
    a4 = ta; b4 = tb; v4 = 1'b1; r4 = 1'b0;
    @(posedge clk); #1;
    v4 = 1'b0;
    tl = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ov4) begin tl = n + 1; break; end
    end
  endtask

  task automatic retire4();
    r4 = 1'b1;
    @(posedge clk); #1;
    r4 = 1'b0;
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, output int tl);
    a8 = ta; b8 = tb; v8 = 1'b1; r8 = 1'b0;
    @(posedge clk); #1;
    v8 = 1'b0;
    tl = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (ov8) begin tl = n + 1; break; end
    end
    r8 = 1'b1;
    @(posedge clk); #1;
    r8 = 1'b0;
  endtask

  logic [3:0] bb_a [3] = '{4'd7, 4'd15, 4'd0};
  logic [3:0] bb_b [3] = '{4'd9, 4'd1, 4'd15};
  logic [7:0] bb_p [3] = '{8'd63, 8'd15, 8'd0};
  logic       exp_v;
  logic [7:0] p_before;

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(ir4), 64'(1));
    chk("rst_out_valid", 64'(ov4), 64'(0));
    chk("rst_p", 64'(p4), 64'(0));
    chk("rst_fault", 64'(f4), 64'(0));
    chk("rst_w32_in_ready", 64'(ir32), 64'(1));
    rst = 1'b0;
    @(posedge clk); #1;

    // 15*15 with exact latency
    op4(4'd15, 4'd15, lat);
    chk("max_latency", 64'(lat), 64'(5));
    chk("max_p", 64'(p4), 64'(225));
    chk("max_fault", 64'(f4), 64'(0));
    retire4();
    chk("max_retired", 64'(ov4), 64'(0));

    // Back-to-back stream, one result every 5 cycles
    a4 = bb_a[0]; b4 = bb_b[0]; v4 = 1'b1; r4 = 1'b1;
    @(posedge clk); #1;
    a4 = bb_a[1]; b4 = bb_b[1];
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      exp_v = (k % 5 == 4);
      chk("b2b_valid", 64'(ov4), 64'(exp_v));
      chk("b2b_in_ready", 64'(ir4), 64'(exp_v || k == 15));
      if (exp_v) chk("b2b_p", 64'(p4), 64'(bb_p[k / 5]));
      if (k == 5) begin a4 = bb_a[2]; b4 = bb_b[2]; end
      if (k == 10) v4 = 1'b0;
    end
    r4 = 1'b0;

    // Backpressure: hold for 10 cycles while new operands are offered
    op4(4'd13, 4'd11, lat);
    chk("bp_latency", 64'(lat), 64'(5));
    a4 = 4'd2; b4 = 4'd2; v4 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(ov4), 64'(1));
      chk("bp_p", 64'(p4), 64'(143));
      chk("bp_fault", 64'(f4), 64'(0));
      chk("bp_in_ready", 64'(ir4), 64'(0));
    end
    v4 = 1'b0; r4 = 1'b1;
    @(posedge clk); #1;
    r4 = 1'b0;
    chk("bp_release_valid", 64'(ov4), 64'(0));
    chk("bp_release_in_ready", 64'(ir4), 64'(1));
    @(posedge clk); #1;
    chk("bp_single_retire", 64'(ov4), 64'(0));

    // Fault injection on a=5, b=6: flip accumulator bit 2
    op4(4'd5, 4'd6, lat);
    chk("fi_clean_p", 64'(p4), 64'(30));
    chk("fi_clean_fault", 64'(f4), 64'(0));
    force dut4.r_acc = 8'd26;
    force dut4n.r_acc = 8'd26;
    #1;
    chk("fi_p", 64'(p4), 64'(26));
    chk("fi_valid", 64'(ov4), 64'(1));
    chk("fi_fault", 64'(f4), 64'(1));
    chk("fi_norc_p", 64'(p4n), 64'(26));
    chk("fi_norc_fault", 64'(f4n), 64'(0));
    release dut4.r_acc;
    release dut4n.r_acc;
    retire4();

    // Asynchronous reset in the middle of BUSY
    a4 = 4'd5; b4 = 4'd5; v4 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0;
    @(posedge clk); #1;
    p_before = p4;
    chk("mid_busy_partial", 64'(p_before != 8'd0), 64'(1));
    #1 rst = 1'b1;
    #1;
    chk("arst_out_valid", 64'(ov4), 64'(0));
    chk("arst_in_ready", 64'(ir4), 64'(1));
    chk("arst_p", 64'(p4), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    op4(4'd9, 4'd11, lat);
    chk("post_rst_latency", 64'(lat), 64'(5));
    chk("post_rst_p", 64'(p4), 64'(99));
    retire4();

    // Exhaustive 4x4 against both residue settings
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        op4(4'(ia), 4'(ib), lat);
        chk("ex_valid", 64'(ov4), 64'(1));
        chk("ex_p", 64'(p4), 64'(ia * ib));
        chk("ex_fault", 64'(f4), 64'(0));
        chk("ex_norc_p", 64'(p4n), 64'(ia * ib));
        retire4();
      end
    end

    // WIDTH=8 early termination
    op8(8'd200, 8'd0, lat);
    chk("et_b0_latency", 64'(lat), 64'(2));
    chk("et_b0_p", 64'(p8), 64'(0));
    op8(8'd3, 8'd1, lat);
    chk("et_b1_latency", 64'(lat), 64'(2));
    chk("et_b1_p", 64'(p8), 64'(3));
    chk("et_b1_fault", 64'(f8), 64'(0));
    op8(8'd255, 8'd128, lat);
    chk("et_msb_latency", 64'(lat), 64'(9));
    chk("et_msb_p", 64'(p8), 64'(32640));
    chk("et_msb_fault", 64'(f8), 64'(0));

    // WIDTH=16 / WIDTH=32, all-ones boundary then random operands
    for (int it = 0; it < 12; it++) begin
      if (it == 0) begin aw = 32'hFFFF_FFFF; bw = 32'hFFFF_FFFF; end
      else begin aw = $urandom; bw = $urandom; end
      vw = 1'b1; rw = 1'b0;
      @(posedge clk); #1;
      vw = 1'b0;
      for (int n = 0; n < 80; n++) begin
        if (ov32) break;
        @(posedge clk); #1;
      end
      chk("w16_valid", 64'(ov16), 64'(1));
      chk("w32_valid", 64'(ov32), 64'(1));
      chk("w16_p", 64'(p16), 64'(32'(aw[15:0]) * 32'(bw[15:0])));
      chk("w16_fault", 64'(f16), 64'(0));
      chk("w32_p", p32, 64'(aw) * 64'(bw));
      chk("w32_fault", 64'(f32), 64'(0));
      rw = 1'b1;
      @(posedge clk); #1;
      rw = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
